// File: rtl/spi_reg_peripheral_pkg.sv
// Shared constants and types for the SPI register peripheral.
// Contents: frame length, register addresses, highest legal address and the
// frame FSM state type.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;  // 1 R/W + 7 address + 8 data
  localparam int unsigned ADDR_BITS  = 7;
  localparam int unsigned DATA_BITS  = 8;

  localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_BITS-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_BITS-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_BITS-1:0] ADDR_PWM_DUTY  = 7'h04;

  localparam int unsigned MAX_ADDR = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin group plus the five control-register outputs.
// master: drives sclk/copi/ncs, observes the registers (host / testbench side).
// slave : receives the pins, drives the registers (peripheral side).
interface spi_reg_peripheral_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
  );

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
  );
endinterface

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin followed by an edge flop.
// Ports: clk, rst (async, active-high), i_pin (asynchronous input),
//        o_level (synchronised level), o_rise / o_fall (one-cycle edge pulses).
// Edges are visible SYNC_STAGES clk cycles after the pin changes; the state
// machine consuming them adds the final cycle of the sync+edge latency.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register target.
// Ports: clk, rst (async, active-high), bus (slave modport: sclk/copi/ncs in,
//        five 8-bit control registers out).
// Deserialises MSB-first frames {R/W, addr[6:0], data[7:0]} and commits a
// write one cycle after chip-select release when the frame is exactly
// FRAME_BITS long, is a write, and targets an address <= MAX_ADDR.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
  parameter int unsigned MAX_ADDR    = spi_reg_pkg::MAX_ADDR
) (
  input logic            clk,
  input logic            rst,
  spi_reg_peripheral_if.slave bus
);
  import spi_reg_pkg::*;

  localparam int unsigned CntW = $clog2(FRAME_BITS + 1);

  logic w_sclk_rise, w_ncs_rise, w_ncs_fall, w_copi;
  logic w_sclk_level_unused, w_sclk_fall_unused, w_ncs_level_unused;
  logic w_copi_rise_unused, w_copi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .i_pin(bus.sclk),
    .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst(rst), .i_pin(bus.copi),
    .o_level(w_copi), .o_rise(w_copi_rise_unused), .o_fall(w_copi_fall_unused)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst(rst), .i_pin(bus.ncs),
    .o_level(w_ncs_level_unused), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  state_t                r_state, w_state_d;
  logic [CntW-1:0]       r_cnt;
  logic                  r_ovf;
  logic [FRAME_BITS-1:0] r_shift;
  logic [7:0]            r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;

  logic                 w_clear, w_shift, w_set_ovf, w_commit, w_frame_ok;
  logic [ADDR_BITS-1:0] w_addr;
  logic [7:0]           w_data;

  assign w_addr     = r_shift[FRAME_BITS-2 -: ADDR_BITS];
  assign w_data     = r_shift[DATA_BITS-1:0];
  assign w_frame_ok = (r_cnt == CntW'(FRAME_BITS)) && !r_ovf && r_shift[FRAME_BITS-1] &&
                      (32'(w_addr) <= MAX_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    w_shift   = 1'b0;
    w_set_ovf = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_clear   = 1'b1;
          w_state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Chip-select release wins over a coincident SCLK edge.
        if (w_ncs_rise) begin
          w_state_d = COMMIT;
        end else if (w_sclk_rise) begin
          if (r_cnt == CntW'(FRAME_BITS)) w_set_ovf = 1'b1;
          else                            w_shift   = 1'b1;
        end
      end
      COMMIT: begin
        w_commit  = w_frame_ok;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_shift <= '0;
    end else if (w_clear) begin
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_shift <= '0;
    end else if (w_shift) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
    end else if (w_set_ovf) begin
      r_ovf   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_lo <= 8'h00;
      r_out_hi <= 8'h00;
      r_pwm_lo <= 8'h00;
      r_pwm_hi <= 8'h00;
      r_duty   <= 8'h00;
    end else if (w_commit) begin
      case (w_addr)
        ADDR_EN_OUT_LO: r_out_lo <= w_data;
        ADDR_EN_OUT_HI: r_out_hi <= w_data;
        ADDR_EN_PWM_LO: r_pwm_lo <= w_data;
        ADDR_EN_PWM_HI: r_pwm_hi <= w_data;
        ADDR_PWM_DUTY:  r_duty   <= w_data;
        default: ;
      endcase
    end
  end

  assign bus.en_reg_out_7_0  = r_out_lo;
  assign bus.en_reg_out_15_8 = r_out_hi;
  assign bus.en_reg_pwm_7_0  = r_pwm_lo;
  assign bus.en_reg_pwm_15_8 = r_pwm_hi;
  assign bus.pwm_duty_cycle  = r_duty;

endmodule
